// File: rtl/in128_out1536.sv
// in128_out1536: packs 128-bit AXI-Stream beats into 1536-bit words of 12 lanes.
// Lane 0 (bits [127:0]) holds the first beat of a word. A beat with tlast closes
// the word early; unwritten lanes are zero and are cleared in m_axis_tkeep.
// The 12-lane closing beat or a tlast beat loads the output register directly
// when the output slot is free. Otherwise the word waits in the accumulator
// (pending) and input is stalled until the held output word is taken.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tlast     128-bit input beat
//   s_axis_tready                 input ready (registered, low only while pending)
//   m_axis_tdata/tvalid           packed 1536-bit output word (valid registered)
//   m_axis_tready                 downstream ready
//   m_axis_tlast                  one-hot lane of the packet's last beat, 0 if closed by fill
//   m_axis_tkeep                  lane-valid mask, lanes 0..n-1 for an n-beat word
module in128_out1536 #(
  parameter int unsigned IN_W  = 128,
  parameter int unsigned LANES = 12,
  parameter int unsigned OUT_W = IN_W * LANES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_W-1:0]    s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic [OUT_W-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [LANES-1:0]   m_axis_tlast,
  output logic [LANES-1:0]   m_axis_tkeep
);

  localparam int unsigned CW = $clog2(LANES);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LANES-1:0] keep_q, keep_d;
  logic [LANES-1:0] last_q, last_d;
  logic             pending_q, pending_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0] out_keep_q, out_keep_d;
  logic [LANES-1:0] out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic [OUT_W-1:0] merged_acc;
  logic [LANES-1:0] merged_keep;
  logic [LANES-1:0] merged_last;
  logic             beat;
  logic             closing;
  logic             slot_free;

  assign s_axis_tready = ~pending_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tkeep  = out_keep_q;

  assign beat      = s_axis_tvalid & ~pending_q;
  assign closing   = beat & (s_axis_tlast | (cnt_q == CW'(LANES - 1)));
  assign slot_free = ~out_valid_q | m_axis_tready;

  // Accumulator contents with the current input beat dropped into lane cnt.
  always_comb begin
    merged_acc  = acc_q;
    merged_keep = keep_q;
    merged_last = last_q;
    for (int i = 0; i < int'(LANES); i++) begin
      if (cnt_q == CW'(i)) begin
        merged_acc[i*IN_W +: IN_W] = s_axis_tdata;
        merged_keep[i]             = 1'b1;
        merged_last[i]             = s_axis_tlast;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    keep_d      = keep_q;
    last_d      = last_q;
    pending_d   = pending_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q & ~m_axis_tready;

    if (pending_q) begin
      // Completed word parked in acc: move it out as soon as the slot frees.
      if (m_axis_tready) begin
        out_data_d  = acc_q;
        out_keep_d  = keep_q;
        out_last_d  = last_q;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        keep_d      = '0;
        last_d      = '0;
        pending_d   = 1'b0;
      end
    end else if (closing) begin
      if (slot_free) begin
        out_data_d  = merged_acc;
        out_keep_d  = merged_keep;
        out_last_d  = merged_last;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        keep_d      = '0;
        last_d      = '0;
      end else begin
        acc_d     = merged_acc;
        keep_d    = merged_keep;
        last_d    = merged_last;
        pending_d = 1'b1;
      end
    end else if (beat) begin
      acc_d  = merged_acc;
      keep_d = merged_keep;
      last_d = merged_last;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      keep_q      <= '0;
      last_q      <= '0;
      pending_q   <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      pending_q   <= pending_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
